accum_drain: RTL and testbench

ACCUM_DRAIN -- requirements
Module: accum_drain

---
 rtl/accum_drain.sv | 114 +++++++++++
 tb/tb_accum_drain.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_drain.sv
// Drains NUM_BANKS accumulator FIFOs, bank-major, row_count words per bank,
// onto a single valid/ready output stream. One word per ISSUE/CAPTURE/HOLD round.
module accum_drain #(
    parameter int NUM_BANKS = 4,
    parameter int DATA_W    = 128,
    parameter int CNT_W     = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [CNT_W-1:0]              row_count,
    input  logic [NUM_BANKS-1:0]          acc_empty,
    output logic [NUM_BANKS-1:0]          accums_rd_en,
    input  logic [NUM_BANKS*DATA_W-1:0]   accum_o_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [DATA_W-1:0]             m_data,
    output logic [((NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1)-1:0] m_bank,
    output logic                          m_last,
    output logic                          busy,
    output logic                          done
);
    localparam int BANK_W = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
    localparam logic [BANK_W-1:0] LAST_BANK = BANK_W'(NUM_BANKS - 1);

    // state   | meaning
    // IDLE    | waiting for start
    // ISSUE   | read strobe to current bank once it is non-empty
    // CAPTURE | read data valid, load output registers
    // HOLD    | word presented, waiting for m_ready
    // FINISH  | one-cycle done pulse
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_CAPTURE = 3'd2;
    localparam logic [2:0] S_HOLD    = 3'd3;
    localparam logic [2:0] S_FINISH  = 3'd4;

    logic [2:0]        state;
    logic [BANK_W-1:0] bank;
    logic [CNT_W-1:0]  row;
    logic [CNT_W-1:0]  count_q;
    logic              row_end;
    logic [DATA_W-1:0] sel_data;

    // count_q is never 0 outside IDLE, so count_q-1 cannot underflow
    assign row_end  = (row == count_q - CNT_W'(1));
    assign sel_data = accum_o_data[int'(bank)*DATA_W +: DATA_W];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= S_IDLE;
            bank    <= '0;
            row     <= '0;
            count_q <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_bank  <= '0;
            m_last  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        bank <= '0;
                        row  <= '0;
                        if (row_count != '0) begin
                            count_q <= row_count;
                            state   <= S_ISSUE;
                        end else begin
                            state <= S_FINISH;
                        end
                    end
                end
                S_ISSUE: begin
                    if (!acc_empty[bank]) state <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    m_data  <= sel_data;
                    m_bank  <= bank;
                    m_last  <= (bank == LAST_BANK) && row_end;
                    m_valid <= 1'b1;
                    state   <= S_HOLD;
                end
                S_HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        if (m_last) begin
                            state <= S_FINISH;
                        end else begin
                            if (row_end) begin
                                row  <= '0;
                                bank <= bank + BANK_W'(1);
                            end else begin
                                row <= row + CNT_W'(1);
                            end
                            state <= S_ISSUE;
                        end
                    end
                end
                S_FINISH: state <= S_IDLE;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // strobes and status are qualified by rst so they read inactive throughout reset
    always_comb begin
        accums_rd_en = '0;
        if (rst && (state == S_ISSUE) && !acc_empty[bank]) accums_rd_en[bank] = 1'b1;
    end

    assign busy = rst && (state != S_IDLE);
    assign done = rst && (state == S_FINISH);

endmodule

// File: tb/tb_accum_drain.sv
// Directed bench for accum_drain: FIFO data model, negedge event logger,
// and one checking task through which every comparison passes.
module tb_accum_drain;
    localparam int NB = 4;
    localparam int DW = 128;
    localparam int CW = 16;

    typedef struct packed {
        logic          last;
        logic [1:0]    bank;
        logic [DW-1:0] data;
    } word_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              m_ready = 1'b0;
    logic [CW-1:0]     row_count = '0;
    logic [NB-1:0]     acc_empty = '0;
    logic [NB-1:0]     accums_rd_en;
    logic [NB*DW-1:0]  accum_o_data;
    logic              m_valid, m_last, busy, done;
    logic [DW-1:0]     m_data;
    logic [1:0]        m_bank;
    logic              model_clr = 1'b1;

    int    rcnt [NB];
    word_t hs_q[$];
    int    hs_cyc[$];
    int    rd_q[$];
    int    done_cyc[$];
    int    cyc = 0, busy_cnt = 0, valid_cnt = 0, multi_rd = 0;
    int    n_chk = 0, n_pass = 0;
    word_t lw;

    accum_drain #(.NUM_BANKS(NB), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .row_count(row_count),
        .acc_empty(acc_empty), .accums_rd_en(accums_rd_en),
        .accum_o_data(accum_o_data), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_bank(m_bank), .m_last(m_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] exp_data(input int b, input int r);
        return {16'hA5C3, 80'h0, 16'(b), 16'(r)};
    endfunction

    // FIFO model: data appears one cycle after the read strobe
    always @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (model_clr) begin
                rcnt[b] <= 0;
            end else if (accums_rd_en[b]) begin
                accum_o_data[b*DW +: DW] <= exp_data(b, rcnt[b]);
                rcnt[b] <= rcnt[b] + 1;
            end
        end
    end

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            for (int b = 0; b < NB; b++) if (accums_rd_en[b]) rd_q.push_back(b);
            if ($countones(accums_rd_en) > 1) multi_rd++;
            if (m_valid && m_ready) begin
                lw.last = m_last;
                lw.bank = m_bank;
                lw.data = m_data;
                hs_q.push_back(lw);
                hs_cyc.push_back(cyc);
            end
            if (done) done_cyc.push_back(cyc);
            if (busy) busy_cnt++;
            if (m_valid) valid_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_model();
        model_clr = 1'b1;
        tick();
        model_clr = 1'b0;
    endtask

    task automatic pulse_start(input int rc);
        row_count = CW'(rc);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_hs(input string tag, input int target, input int budget);
        int n = 0;
        while (hs_q.size() < target && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_hs_timeout"}, (hs_q.size() >= target), 1);
    endtask

    task automatic wait_done(input string tag, input int target, input int budget);
        int n = 0;
        while (done_cyc.size() < target && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_done_timeout"}, (done_cyc.size() >= target), 1);
    endtask

    task automatic check_words(input string tag, input int base, input int rows,
                               input int nwords, input int total);
        word_t w;
        int b, r;
        for (int k = 0; k < nwords; k++) begin
            b = k / rows;
            r = k % rows;
            if (base + k < hs_q.size()) begin
                w = hs_q[base + k];
                chk($sformatf("%s_bank%0d", tag, k), w.bank, b);
                chk($sformatf("%s_data%0d", tag, k), w.data, exp_data(b, r));
                chk($sformatf("%s_last%0d", tag, k), w.last, (k == total - 1));
            end else begin
                chk($sformatf("%s_missing%0d", tag, k), 0, 1);
            end
        end
    endtask

    task automatic check_reads(input string tag, input int base, input int rows, input int n);
        chk({tag, "_rd_count"}, rd_q.size() - base, n);
        for (int k = 0; k < n; k++)
            if (base + k < rd_q.size()) chk($sformatf("%s_rd%0d", tag, k), rd_q[base + k], k / rows);
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_rd_en"},   accums_rd_en, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"},  m_data, 0);
        chk({tag, "_m_bank"},  m_bank, 0);
        chk({tag, "_m_last"},  m_last, 0);
        chk({tag, "_busy"},    busy, 0);
        chk({tag, "_done"},    done, 0);
    endtask

    initial begin
        int hb, rb, db, bb, vb, n;
        logic [DW-1:0] d0;
        logic [1:0]    b0;
        logic          l0;

        // reset state
        repeat (3) tick();
        check_reset_outs("rst");
        rst = 1'b1;
        tick();
        model_clr = 1'b0;

        // row_count=2, no stalls: bank order 0,0,1,1,2,2,3,3 at one word per 3 cycles
        clr_model();
        m_ready = 1'b1;
        hb = hs_q.size(); rb = rd_q.size(); db = done_cyc.size();
        pulse_start(2);
        chk("basic_busy", busy, 1);
        wait_done("basic", db + 1, 100);
        repeat (3) tick();
        check_reads("basic", rb, 2, 8);
        chk("basic_hs_count", hs_q.size() - hb, 8);
        check_words("basic", hb, 2, 8, 8);
        chk("basic_done_count", done_cyc.size() - db, 1);
        if (done_cyc.size() > db && hs_q.size() >= hb + 8) begin
            chk("basic_done_lat", done_cyc[db] - hs_cyc[hb + 7], 1);
            for (int k = 0; k < 7; k++)
                chk($sformatf("basic_rate%0d", k), hs_cyc[hb + k + 1] - hs_cyc[hb + k], 3);
        end
        chk("basic_idle_busy", busy, 0);

        // backpressure after the first word
        clr_model();
        m_ready = 1'b0;
        hb = hs_q.size(); rb = rd_q.size(); db = done_cyc.size();
        pulse_start(1);
        n = 0;
        while (!m_valid && n < 10) begin tick(); n++; end
        chk("bp_valid_timeout", m_valid, 1);
        d0 = m_data; b0 = m_bank; l0 = m_last;
        chk("bp_first_data", d0, exp_data(0, 0));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_data%0d", i),  m_data, d0);
            chk($sformatf("bp_bank%0d", i),  m_bank, b0);
            chk($sformatf("bp_last%0d", i),  m_last, l0);
            chk($sformatf("bp_valid%0d", i), m_valid, 1);
            chk($sformatf("bp_rd%0d", i),    accums_rd_en, 0);
        end
        m_ready = 1'b1;
        wait_done("bp", db + 1, 60);
        repeat (2) tick();
        chk("bp_hs_count", hs_q.size() - hb, 4);
        check_words("bp", hb, 1, 4, 4);
        check_reads("bp", rb, 1, 4);

        // bank 1 empty for 10 cycles when reached
        clr_model();
        acc_empty = 4'b0010;
        hb = hs_q.size(); rb = rd_q.size(); db = done_cyc.size();
        pulse_start(1);
        wait_hs("empty", hb + 1, 20);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("empty_rd%0d", i), accums_rd_en, 0);
            chk($sformatf("empty_busy%0d", i), busy, 1);
            tick();
        end
        acc_empty = 4'b0000;
        #1;
        chk("empty_rd_release", accums_rd_en, 4'b0010);
        wait_done("empty", db + 1, 60);
        repeat (2) tick();
        check_words("empty", hb, 1, 4, 4);
        check_reads("empty", rb, 1, 4);

        // row_count=0: straight to FINISH
        hb = hs_q.size(); rb = rd_q.size(); db = done_cyc.size();
        bb = busy_cnt; vb = valid_cnt;
        pulse_start(0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 1);
        tick();
        chk("zero_done_low", done, 0);
        repeat (4) tick();
        chk("zero_busy_cycles", busy_cnt - bb, 1);
        chk("zero_done_count", done_cyc.size() - db, 1);
        chk("zero_valid_cycles", valid_cnt - vb, 0);
        chk("zero_rd_count", rd_q.size() - rb, 0);

        // reset during HOLD of word 3, then a clean row_count=1 job
        clr_model();
        m_ready = 1'b1;
        db = done_cyc.size();
        pulse_start(1);
        n = 0;
        while (!(m_valid && m_bank == 2'd2) && n < 30) begin tick(); n++; end
        chk("abort_reach_word3", (m_valid && m_bank == 2'd2), 1);
        rst = 1'b0;
        m_ready = 1'b0;
        tick();
        check_reset_outs("abort");
        rst = 1'b1;
        tick();
        chk("abort_idle_busy", busy, 0);
        chk("abort_no_done", done_cyc.size() - db, 0);
        clr_model();
        m_ready = 1'b1;
        hb = hs_q.size(); rb = rd_q.size(); db = done_cyc.size();
        pulse_start(1);
        wait_done("post_abort", db + 1, 60);
        repeat (2) tick();
        chk("post_abort_hs_count", hs_q.size() - hb, 4);
        check_words("post_abort", hb, 1, 4, 4);
        chk("post_abort_done_count", done_cyc.size() - db, 1);

        // second start mid-job is ignored
        clr_model();
        hb = hs_q.size(); rb = rd_q.size(); db = done_cyc.size();
        pulse_start(2);
        repeat (5) tick();
        row_count = 16'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("restart", db + 1, 100);
        repeat (5) tick();
        chk("restart_hs_count", hs_q.size() - hb, 8);
        check_words("restart", hb, 2, 8, 8);
        check_reads("restart", rb, 2, 8);
        chk("restart_done_count", done_cyc.size() - db, 1);

        // maximum row_count: first words stay in bank 0 and never flag last
        clr_model();
        hb = hs_q.size();
        pulse_start(16'hFFFF);
        wait_hs("maxrc", hb + 5, 40);
        check_words("maxrc", hb, 65535, 5, 262140);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("maxrc_abort_busy", busy, 0);

        chk("rd_en_onehot", multi_rd, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
